// File: rtl/acc_req_arbiter.sv
// Round-robin arbiter sharing one accelerator request channel among NrPorts,
// with an in-order source-ID queue that routes responses back to requesters.
module acc_req_arbiter #(
  parameter int unsigned NrPorts        = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned ReqWidth       = 128,
  parameter int unsigned RespWidth      = 80
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NrPorts-1:0]                req_valid_i,
  output logic [NrPorts-1:0]                req_ready_o,
  input  logic [NrPorts*ReqWidth-1:0]       req_data_i,
  output logic                              acc_req_valid_o,
  input  logic                              acc_req_ready_i,
  output logic [ReqWidth-1:0]               acc_req_o,
  input  logic                              acc_resp_valid_i,
  output logic                              acc_resp_ready_o,
  input  logic [RespWidth-1:0]              acc_resp_i,
  output logic [NrPorts-1:0]                resp_valid_o,
  input  logic [NrPorts-1:0]                resp_ready_i,
  output logic [RespWidth-1:0]              resp_data_o,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
  output logic                              resp_unexpected_o
);

  localparam int unsigned PortW = (NrPorts > 1) ? $clog2(NrPorts) : 1;
  localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);

  logic [PortW-1:0] rr_q, rr_d;
  logic             lock_q, lock_d;
  logic [PortW-1:0] lock_port_q, lock_port_d;
  logic [PortW-1:0] id_q [MaxOutstanding];
  logic [PortW-1:0] id_d [MaxOutstanding];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             unexp_q, unexp_d;

  logic [PortW-1:0] sel;
  logic [PortW:0]   scan;
  logic             found;
  logic             full, empty;
  logic             push, pop;
  logic [PortW-1:0] head;

  assign full  = (count_q == CntW'(MaxOutstanding));
  assign empty = (count_q == '0);
  assign head  = id_q[rptr_q];

  // Scan from rr_q upward with wrap; a stalled grant stays locked.
  always_comb begin
    sel   = rr_q;
    scan  = '0;
    found = 1'b0;
    if (lock_q) begin
      sel = lock_port_q;
    end else begin
      for (int i = 0; i < NrPorts; i++) begin
        scan = {1'b0, rr_q} + (PortW+1)'(i);
        if (scan >= (PortW+1)'(NrPorts)) begin
          scan = scan - (PortW+1)'(NrPorts);
        end
        if (!found && req_valid_i[scan[PortW-1:0]]) begin
          sel   = scan[PortW-1:0];
          found = 1'b1;
        end
      end
    end
  end

  assign acc_req_valid_o = !rst_i && req_valid_i[sel] && !full;
  assign acc_req_o       = req_data_i[sel*ReqWidth +: ReqWidth];
  assign push            = acc_req_valid_o && acc_req_ready_i;

  always_comb begin
    req_ready_o      = '0;
    req_ready_o[sel] = !rst_i && acc_req_ready_i && !full;
  end

  always_comb begin
    resp_valid_o     = '0;
    acc_resp_ready_o = 1'b0;
    if (!rst_i && !empty) begin
      resp_valid_o[head] = acc_resp_valid_i;
      acc_resp_ready_o   = resp_ready_i[head];
    end
  end

  assign pop               = acc_resp_valid_i && acc_resp_ready_o;
  assign resp_data_o       = acc_resp_i;
  assign outstanding_o     = count_q;
  assign resp_unexpected_o = unexp_q;

  always_comb begin
    rr_d        = rr_q;
    lock_d      = lock_q;
    lock_port_d = lock_port_q;
    if (push) begin
      rr_d   = (sel == PortW'(NrPorts-1)) ? '0 : sel + PortW'(1);
      lock_d = 1'b0;
    end else if (acc_req_valid_o) begin
      lock_d      = 1'b1;
      lock_port_d = sel;
    end
  end

  always_comb begin
    id_d   = id_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      id_d[wptr_q] = sel;
      wptr_d = (wptr_q == PtrW'(MaxOutstanding-1)) ? '0 : wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == PtrW'(MaxOutstanding-1)) ? '0 : rptr_q + PtrW'(1);
    end
  end

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  assign unexp_d = unexp_q || (acc_resp_valid_i && empty);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q        <= '0;
      lock_q      <= 1'b0;
      lock_port_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      unexp_q     <= 1'b0;
      for (int i = 0; i < MaxOutstanding; i++) begin
        id_q[i] <= '0;
      end
    end else begin
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      lock_port_q <= lock_port_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      unexp_q     <= unexp_d;
      id_q        <= id_d;
    end
  end

endmodule

// File: tb/tb_acc_req_arbiter.sv
// Scoreboard bench for acc_req_arbiter: directed request/response
// vectors with expected grant and routing order queued up front.
module tb_acc_req_arbiter;

  localparam int NP = 3;
  localparam int MO = 4;
  localparam int RW = 16;
  localparam int SW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] req_valid;
  logic [NP-1:0] req_ready_o;
  logic [NP*RW-1:0] req_data;
  logic          acc_req_valid_o;
  logic          acc_req_ready;
  logic [RW-1:0] acc_req_o;
  logic          acc_resp_valid;
  logic          acc_resp_ready_o;
  logic [SW-1:0] acc_resp_data;
  logic [NP-1:0] resp_valid_o;
  logic [NP-1:0] resp_ready;
  logic [SW-1:0] resp_data_o;
  logic [2:0]    outstanding_o;
  logic          resp_unexpected_o;

  int n_cmp = 0;
  int n_bad = 0;

  int            exp_req_port[$];
  int            exp_rsp_port[$];
  logic [SW-1:0] exp_rsp_data[$];

  always #5 clk = ~clk;

  acc_req_arbiter #(
    .NrPorts(NP), .MaxOutstanding(MO),
    .ReqWidth(RW), .RespWidth(SW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready_o),
    .req_data_i(req_data),
    .acc_req_valid_o(acc_req_valid_o),
    .acc_req_ready_i(acc_req_ready),
    .acc_req_o(acc_req_o),
    .acc_resp_valid_i(acc_resp_valid),
    .acc_resp_ready_o(acc_resp_ready_o),
    .acc_resp_i(acc_resp_data),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready),
    .resp_data_o(resp_data_o),
    .outstanding_o(outstanding_o),
    .resp_unexpected_o(resp_unexpected_o)
  );

  function automatic logic [RW-1:0] pdata(input int p);
    return RW'(16'hA000 + p * 256 + 8'h5C);
  endfunction

  function automatic int port_of(input logic [RW-1:0] d);
    for (int p = 0; p < NP; p++) if (d == pdata(p)) return p;
    return 0;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    int p;
    if (!rst && acc_req_valid_o && acc_req_ready) begin
      if (exp_req_port.size() == 0) begin
        check("req_extra", 1, 0);
      end else begin
        p = exp_req_port.pop_front();
        check("req_ready", 64'(req_ready_o), 64'(1 << p));
        check("req_data", 64'(acc_req_o), 64'(pdata(p)));
      end
    end
  end

  always @(negedge clk) begin
    int p;
    logic [SW-1:0] d;
    if (!rst && acc_resp_valid && acc_resp_ready_o) begin
      if (exp_rsp_port.size() == 0) begin
        check("rsp_extra", 1, 0);
      end else begin
        p = exp_rsp_port.pop_front();
        d = exp_rsp_data.pop_front();
        check("rsp_valid", 64'(resp_valid_o), 64'(1 << p));
        check("rsp_data", 64'(resp_data_o), 64'(d));
      end
    end
  end

  logic lk = 1'b0;
  int   lk_p = 0;
  always @(negedge clk) begin
    if (lk && !rst)
      assert (req_valid[lk_p]) else $error("requester dropped valid while locked");
    lk   <= !rst && acc_req_valid_o && !acc_req_ready;
    lk_p <= port_of(acc_req_o);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1[4]  = '{0, 1, 0, 1};
    int t3[3]  = '{2, 0, 2};
    int t5[4]  = '{1, 0, 1, 1};
    rst            = 1'b1;
    req_data       = {pdata(2), pdata(1), pdata(0)};
    req_valid      = '1;
    acc_req_ready  = 1'b1;
    acc_resp_valid = 1'b1;
    acc_resp_data  = '0;
    resp_ready     = '1;

    @(negedge clk);
    check("rst_acc_req_valid", 64'(acc_req_valid_o), 0);
    check("rst_req_ready", 64'(req_ready_o), 0);
    check("rst_resp_valid", 64'(resp_valid_o), 0);
    check("rst_acc_resp_ready", 64'(acc_resp_ready_o), 0);
    check("rst_outstanding", 64'(outstanding_o), 0);
    check("rst_unexpected", 64'(resp_unexpected_o), 0);

    tick();
    rst            = 1'b0;
    req_valid      = '0;
    acc_resp_valid = 1'b0;
    resp_ready     = '0;

    // Alternating grants until full
    req_valid = 3'b011;
    foreach (t1[i]) exp_req_port.push_back(t1[i]);
    repeat (4) @(posedge clk);
    #1;
    check("t1_out_full", 64'(outstanding_o), 4);
    @(negedge clk);
    check("t1_full_valid", 64'(acc_req_valid_o), 0);
    check("t1_full_ready", 64'(req_ready_o), 0);
    tick();
    req_valid  = '0;
    resp_ready = '1;
    for (int i = 0; i < 4; i++) begin
      exp_rsp_port.push_back(t1[i]);
      exp_rsp_data.push_back(SW'(12'h100 + i));
      acc_resp_valid = 1'b1;
      acc_resp_data  = SW'(12'h100 + i);
      tick();
    end
    acc_resp_valid = 1'b0;
    check("t1_out_empty", 64'(outstanding_o), 0);

    // Grant lock on port 1
    acc_req_ready = 1'b0;
    req_valid     = 3'b010;
    @(negedge clk);
    check("lock_c1_valid", 64'(acc_req_valid_o), 1);
    check("lock_c1_data", 64'(acc_req_o), 64'(pdata(1)));
    tick();
    req_valid = 3'b011;
    @(negedge clk);
    check("lock_c2_data", 64'(acc_req_o), 64'(pdata(1)));
    check("lock_c2_ready", 64'(req_ready_o), 0);
    tick();
    @(negedge clk);
    check("lock_c3_data", 64'(acc_req_o), 64'(pdata(1)));
    tick();
    acc_req_ready = 1'b1;
    exp_req_port.push_back(1);
    exp_req_port.push_back(0);
    tick();
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    check("t2_out", 64'(outstanding_o), 2);

    // Response backpressure at head port 0
    resp_ready     = '1;
    acc_resp_valid = 1'b1;
    acc_resp_data  = SW'(12'h201);
    exp_rsp_port.push_back(1);
    exp_rsp_data.push_back(SW'(12'h201));
    tick();
    resp_ready    = 3'b110;
    acc_resp_data = SW'(12'h202);
    exp_rsp_port.push_back(0);
    exp_rsp_data.push_back(SW'(12'h202));
    @(negedge clk);
    check("hold1_ready", 64'(acc_resp_ready_o), 0);
    check("hold1_valid", 64'(resp_valid_o), 64'(3'b001));
    tick();
    @(negedge clk);
    check("hold2_ready", 64'(acc_resp_ready_o), 0);
    check("hold2_out", 64'(outstanding_o), 1);
    tick();
    resp_ready = '1;
    tick();
    acc_resp_valid = 1'b0;
    check("t4_out", 64'(outstanding_o), 0);

    // Ports 2,0,2 then in-order responses
    req_valid = 3'b100;
    exp_req_port.push_back(2);
    tick();
    req_valid = 3'b001;
    exp_req_port.push_back(0);
    tick();
    req_valid = 3'b100;
    exp_req_port.push_back(2);
    tick();
    req_valid = '0;
    check("t3_out3", 64'(outstanding_o), 3);
    for (int i = 0; i < 3; i++) begin
      exp_rsp_port.push_back(t3[i]);
      exp_rsp_data.push_back(SW'(12'h300 + i));
      acc_resp_valid = 1'b1;
      acc_resp_data  = SW'(12'h300 + i);
      tick();
      check("t3_out_dec", 64'(outstanding_o), 64'(2 - i));
    end
    acc_resp_valid = 1'b0;

    // Full with same-cycle pop: no bypass
    req_valid = 3'b011;
    foreach (t1[i]) exp_req_port.push_back(t1[i]);
    repeat (4) tick();
    req_valid      = 3'b010;
    acc_resp_valid = 1'b1;
    acc_resp_data  = SW'(12'h400);
    exp_rsp_port.push_back(0);
    exp_rsp_data.push_back(SW'(12'h400));
    exp_req_port.push_back(1);
    check("t5_out4", 64'(outstanding_o), 4);
    @(negedge clk);
    check("t5_full_noreq", 64'(acc_req_valid_o), 0);
    check("t5_full_ready", 64'(req_ready_o), 0);
    tick();
    acc_resp_valid = 1'b0;
    check("t5_out3", 64'(outstanding_o), 3);
    tick();
    req_valid = '0;
    check("t5_out4b", 64'(outstanding_o), 4);
    for (int i = 0; i < 4; i++) begin
      exp_rsp_port.push_back(t5[i]);
      exp_rsp_data.push_back(SW'(12'h410 + i));
      acc_resp_valid = 1'b1;
      acc_resp_data  = SW'(12'h410 + i);
      tick();
    end
    acc_resp_valid = 1'b0;
    check("t5_out0", 64'(outstanding_o), 0);

    // Unexpected response, then reset mid-burst
    acc_resp_valid = 1'b1;
    @(negedge clk);
    check("unexp_ready", 64'(acc_resp_ready_o), 0);
    check("unexp_valid", 64'(resp_valid_o), 0);
    check("unexp_pre", 64'(resp_unexpected_o), 0);
    tick();
    acc_resp_valid = 1'b0;
    check("unexp_set", 64'(resp_unexpected_o), 1);
    tick();
    check("unexp_sticky", 64'(resp_unexpected_o), 1);
    req_valid = 3'b011;
    exp_req_port.push_back(0);
    exp_req_port.push_back(1);
    tick();
    tick();
    check("burst_out", 64'(outstanding_o), 2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out", 64'(outstanding_o), 0);
    check("arst_unexp", 64'(resp_unexpected_o), 0);
    check("arst_valid", 64'(acc_req_valid_o), 0);
    check("arst_ready", 64'(req_ready_o), 0);
    tick();
    rst       = 1'b0;
    req_valid = '0;
    tick();
    check("post_rst_out", 64'(outstanding_o), 0);
    check("post_rst_unexp", 64'(resp_unexpected_o), 0);
    check("sb_req_empty", 64'(exp_req_port.size()), 0);
    check("sb_rsp_empty", 64'(exp_rsp_port.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/acc_req_arbiter.md
Name: acc_req_arbiter

Overview:
- Shares one accelerator request/response channel among NrPorts requesters, e.g. several accelerator dispatchers or a dispatcher plus a debug/DMA injector.
- Arbitration is round-robin with a grant lock, so a presented request stays stable until it is accepted.
- The block records the source port of every accepted request in an in-order ID queue.
- Accelerator responses are routed back to the originating port. The accelerator answers in request order.

Parameters:
- NrPorts, 2, number of requesters (≥2).
- MaxOutstanding, 4, maximum accepted-but-unanswered requests (≥1).
- ReqWidth, 128, width of one flattened request payload.
- RespWidth, 80, width of one flattened response payload.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- req_valid_i  in  NrPorts  per-port request valid.
- req_ready_o  out  NrPorts  per-port request accepted.
- req_data_i  in  NrPorts*ReqWidth  per-port payload; port p occupies bits [p*ReqWidth +: ReqWidth].
- acc_req_valid_o  out  1  request to accelerator.
- acc_req_ready_i  in  1  accelerator accepts request.
- acc_req_o  out  ReqWidth  selected payload.
- acc_resp_valid_i  in  1  accelerator response valid.
- acc_resp_ready_o  out  1  response consumed.
- acc_resp_i  in  RespWidth  response payload.
- resp_valid_o  out  NrPorts  per-port response valid.
- resp_ready_i  in  NrPorts  per-port response ready.
- resp_data_o  out  RespWidth  response payload, broadcast to all ports.
- outstanding_o  out  idx_width(MaxOutstanding+1)  in-flight request count.
- resp_unexpected_o  out  1  sticky error flag.

Behaviour:
- Reset (rst_i high, asynchronous, any cycle including mid-transaction):
  - rr_q=0, lock_q=0, ID queue empty, count=0, resp_unexpected_o=0.
  - All valid/ready outputs are 0 while reset is held.
- Arbitration, combinational, zero-cycle latency from req_valid_i to acc_req_valid_o:
  - If lock_q=1: the selected port is locked_port_q.
  - Else: the selected port is the first p with req_valid_i[p]=1, scanning from rr_q upward with wrap at NrPorts.
- Outputs of the selected port s:
  - acc_req_valid_o = req_valid_i[s] && !full.
  - acc_req_o = slice s.
  - req_ready_o[s] = acc_req_ready_i && !full; all other ports get ready 0.
- Lock:
  - If acc_req_valid_o=1 and acc_req_ready_i=0, set lock_q=1 and locked_port_q=s. The grant holds until the handshake.
  - Requesters must hold valid and data stable once presented.
  - The bench asserts that a requester does not drop valid while locked.
- Handshake (acc_req_valid_o && acc_req_ready_i):
  - Push s into the ID queue.
  - rr_q <= (s+1) mod NrPorts.
  - lock_q <= 0.
- full means count==MaxOutstanding. While full:
  - No request is issued and the lock does not change.
  - A response popped in the same cycle frees a slot only from the next cycle; there is no same-cycle bypass.
- Response routing, with h = ID queue head:
  - If the queue is non-empty:
    - resp_valid_o[h] = acc_resp_valid_i.
    - acc_resp_ready_o = resp_ready_i[h].
    - resp_valid_o for all other ports = 0.
  - Pop when acc_resp_valid_i && acc_resp_ready_o.
- Response arriving while the queue is empty:
  - acc_resp_ready_o=0 and no resp_valid_o is asserted.
  - resp_unexpected_o is set and stays 1 until reset.
- Simultaneous push and pop:
  - count is unchanged.
  - Queue order is preserved; the head advances while the tail is written.
- Counter and queue:
  - The ID queue is a circular buffer of MaxOutstanding entries, each idx_width(NrPorts) wide.
  - Pointers wrap modulo MaxOutstanding.
  - count ranges over 0..MaxOutstanding; outstanding_o = count.
- No flush input: outstanding accelerator operations always complete and their responses are always delivered.

Test Plan:
- Ports 0 and 1 both valid every cycle, acc_req_ready_i=1, NrPorts=2 → grants alternate 0,1,0,1. outstanding_o increments to 4 and then acc_req_valid_o=0 while full.
- Port 1 valid with acc_req_ready_i=0 for 3 cycles, port 0 asserts valid in cycle 2 → acc_req_o stays port 1 data for all 3 cycles. After port 1 is accepted, the next grant goes to port 0.
- Accept requests from ports 2,0,2 (NrPorts=3), then return 3 responses → resp_valid_o goes to ports 2, 0, 2 in that order. outstanding_o goes 3→0.
- Head response for port 0 with resp_ready_i[0]=0 for 2 cycles → acc_resp_ready_o=0 during those 2 cycles. Data is delivered on the 3rd cycle and the queue pops once.
- count=4 (full), same cycle response pop and port 1 request valid → the request is not accepted that cycle and is accepted next cycle. count goes 4→3→4.
- acc_resp_valid_i=1 with an empty queue → resp_unexpected_o=1 from the next cycle, acc_resp_ready_o=0. Assert rst_i mid-burst → all state clears asynchronously and the flag returns to 0.
